// File: rtl/simple_processor_pkg.sv
// Shared types for the simple processor: ALU function codes, opcode map,
// decoded-field bundle and the combinational instruction decoder.
package simple_processor_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int IMM_WIDTH      = 6;
    localparam int OPCODE_WIDTH   = 6;

    typedef enum logic [3:0] {
        ADD, ADDI, SUB, LAND, LOR, LXOR, SLL, SLLI, SLR, SLRI, INVALID
    } func_t;

    localparam logic [OPCODE_WIDTH-1:0] OP_SLL  = 6'h00;
    localparam logic [OPCODE_WIDTH-1:0] OP_SLLI = 6'h01;
    localparam logic [OPCODE_WIDTH-1:0] OP_SLR  = 6'h02;
    localparam logic [OPCODE_WIDTH-1:0] OP_SLRI = 6'h03;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = 6'h04;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = 6'h05;
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = 6'h06;
    localparam logic [OPCODE_WIDTH-1:0] OP_AND  = 6'h07;
    localparam logic [OPCODE_WIDTH-1:0] OP_OR   = 6'h08;
    localparam logic [OPCODE_WIDTH-1:0] OP_XOR  = 6'h09;

    typedef struct packed {
        func_t                     func;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [REG_ADDR_WIDTH-1:0] rs1;
        logic [REG_ADDR_WIDTH-1:0] rs2;
        logic [IMM_WIDTH-1:0]      imm;
        logic                      illegal;
    } dec_fields_t;

    localparam dec_fields_t DEC_RESET = '{
        func: INVALID, rd: '0, rs1: '0, rs2: '0, imm: '0, illegal: 1'b0
    };

    // Bits [10:6] are reserved; register and immediate fields pass through
    // even for an unknown opcode.
    function automatic dec_fields_t decode_instr(input logic [DATA_WIDTH-1:0] instr);
        dec_fields_t d;
        d.rd      = instr[25:21];
        d.rs1     = instr[20:16];
        d.rs2     = instr[15:11];
        d.imm     = instr[5:0];
        d.illegal = 1'b0;
        case (instr[31:26])
            OP_SLL:  d.func = SLL;
            OP_SLLI: d.func = SLLI;
            OP_SLR:  d.func = SLR;
            OP_SLRI: d.func = SLRI;
            OP_ADD:  d.func = ADD;
            OP_ADDI: d.func = ADDI;
            OP_SUB:  d.func = SUB;
            OP_AND:  d.func = LAND;
            OP_OR:   d.func = LOR;
            OP_XOR:  d.func = LXOR;
            default: begin
                d.func    = INVALID;
                d.illegal = 1'b1;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry valid/ready buffer (registered main output + skid) with flush.
// in_ready comes only from registered state and reset, never from out_ready.
module skid_buffer #(
    parameter type T         = logic [7:0],
    parameter T    RESET_VAL = '0
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  T     in_data,
    input  logic in_valid,
    output logic in_ready,
    output T     out_data,
    output logic out_valid,
    input  logic out_ready
);

    T     skid_data;
    logic skid_valid;
    logic in_fire;
    logic out_fire;

    assign in_ready = !skid_valid && !rst;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_data   <= RESET_VAL;
            skid_data  <= RESET_VAL;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!out_valid || out_fire) begin
            // in_ready is low whenever skid is occupied, so no collision here
            if (skid_valid) begin
                out_data   <= skid_data;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= in_fire;
                if (in_fire) out_data <= in_data;
            end
        end else if (in_fire) begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/instr_decoder.sv
// Decode stage: decodes fetch words combinationally, buffers decoded fields in
// a two-entry skid buffer, and counts instructions handed to execute.
module instr_decoder
    import simple_processor_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [DATA_WIDTH-1:0]     instr_i,
    input  logic                      instr_valid_i,
    output logic                      instr_ready_o,
    input  logic                      flush_i,
    output func_t                     func_o,
    output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
    output logic [REG_ADDR_WIDTH-1:0] rs1_addr_o,
    output logic [REG_ADDR_WIDTH-1:0] rs2_addr_o,
    output logic [IMM_WIDTH-1:0]      imm_o,
    output logic                      illegal_o,
    output logic                      dec_valid_o,
    input  logic                      dec_ready_i,
    output logic [15:0]               dec_count_o,
    output logic [7:0]                illegal_count_o
);

    dec_fields_t in_fields;
    dec_fields_t out_fields;
    logic        out_fire;
    logic        reserved_unused;

    assign in_fields       = decode_instr(instr_i);
    assign reserved_unused = ^instr_i[10:6];

    skid_buffer #(
        .T         (dec_fields_t),
        .RESET_VAL (DEC_RESET)
    ) u_skid (
        .clk       (clk_i),
        .rst       (rst_i),
        .flush     (flush_i),
        .in_data   (in_fields),
        .in_valid  (instr_valid_i),
        .in_ready  (instr_ready_o),
        .out_data  (out_fields),
        .out_valid (dec_valid_o),
        .out_ready (dec_ready_i)
    );

    assign func_o     = out_fields.func;
    assign rd_addr_o  = out_fields.rd;
    assign rs1_addr_o = out_fields.rs1;
    assign rs2_addr_o = out_fields.rs2;
    assign imm_o      = out_fields.imm;
    assign illegal_o  = out_fields.illegal;

    // An output handshake in a flush cycle still counts.
    assign out_fire = dec_valid_o && dec_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dec_count_o     <= '0;
            illegal_count_o <= '0;
        end else if (out_fire) begin
            dec_count_o <= dec_count_o + 16'd1;
            if (illegal_o && illegal_count_o != 8'hFF)
                illegal_count_o <= illegal_count_o + 8'd1;
        end
    end

endmodule

// File: tb/tb_instr_decoder.sv
// Self-checking bench for instr_decoder: directed vector table, corner
// sequences and randomized traffic against a FIFO-level reference model.
module tb_instr_decoder;
    import simple_processor_pkg::*;

    logic        clk;
    logic        rst_i;
    logic [31:0] instr_i;
    logic        instr_valid_i;
    logic        instr_ready_o;
    logic        flush_i;
    func_t       func_o;
    logic [4:0]  rd_addr_o, rs1_addr_o, rs2_addr_o;
    logic [5:0]  imm_o;
    logic        illegal_o;
    logic        dec_valid_o;
    logic        dec_ready_i;
    logic [15:0] dec_count_o;
    logic [7:0]  illegal_count_o;

    instr_decoder dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .instr_i         (instr_i),
        .instr_valid_i   (instr_valid_i),
        .instr_ready_o   (instr_ready_o),
        .flush_i         (flush_i),
        .func_o          (func_o),
        .rd_addr_o       (rd_addr_o),
        .rs1_addr_o      (rs1_addr_o),
        .rs2_addr_o      (rs2_addr_o),
        .imm_o           (imm_o),
        .illegal_o       (illegal_o),
        .dec_valid_o     (dec_valid_o),
        .dec_ready_i     (dec_ready_i),
        .dec_count_o     (dec_count_o),
        .illegal_count_o (illegal_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: ordered queue of at most two decoded words plus counters.
    func_t       opmap [64];
    dec_fields_t m_q[$];
    logic [15:0] m_dec = '0;
    logic [7:0]  m_ill = '0;
    bit          m_rst = 1'b1;

    typedef struct {
        logic [31:0] ins;
        func_t       f;
        logic [4:0]  rd, rs1, rs2;
        logic [5:0]  imm;
        logic        ill;
    } vec_t;
    vec_t vt [8];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [4:0] res, input logic [5:0] imm);
        return {op, rd, rs1, rs2, res, imm};
    endfunction

    function automatic dec_fields_t ref_decode(input logic [31:0] w);
        dec_fields_t f;
        f.func    = opmap[w[31:26]];
        f.illegal = (f.func == INVALID);
        f.rd      = w[25:21];
        f.rs1     = w[20:16];
        f.rs2     = w[15:11];
        f.imm     = w[5:0];
        return f;
    endfunction

    task automatic chk_fields(input string tag, input dec_fields_t e);
        chk({tag, "_func"},    32'(func_o),     32'(e.func));
        chk({tag, "_rd"},      32'(rd_addr_o),  32'(e.rd));
        chk({tag, "_rs1"},     32'(rs1_addr_o), 32'(e.rs1));
        chk({tag, "_rs2"},     32'(rs2_addr_o), 32'(e.rs2));
        chk({tag, "_imm"},     32'(imm_o),      32'(e.imm));
        chk({tag, "_illegal"}, 32'(illegal_o),  32'(e.illegal));
    endtask

    task automatic check_model();
        dec_fields_t rv;
        rv.func = INVALID; rv.rd = '0; rv.rs1 = '0; rv.rs2 = '0; rv.imm = '0; rv.illegal = 1'b0;
        chk("ready", 32'(instr_ready_o), 32'(m_q.size() < 2 && !rst_i));
        chk("dec_valid", 32'(dec_valid_o), 32'(m_q.size() > 0));
        if (m_q.size() > 0) chk_fields("out", m_q[0]);
        else if (m_rst) chk_fields("rstval", rv);
        chk("dec_count", 32'(dec_count_o), 32'(m_dec));
        chk("illegal_count", 32'(illegal_count_o), 32'(m_ill));
    endtask

    // One clock: drive at negedge, check model state, then advance the model at posedge.
    task automatic cycle(input logic v, input logic [31:0] w, input logic dr,
                         input logic fl, input logic rs, output bit acc);
        bit fin, fout;
        @(negedge clk);
        instr_valid_i = v; instr_i = w; dec_ready_i = dr; flush_i = fl; rst_i = rs;
        #1;
        check_model();
        fin  = v && (m_q.size() < 2) && !rs && !fl;
        fout = (m_q.size() > 0) && dr && !rs;
        acc  = fin;
        @(posedge clk);
        if (rs) begin
            m_q.delete(); m_dec = '0; m_ill = '0; m_rst = 1'b1;
        end else begin
            if (fout) begin
                m_dec++;
                if (m_q[0].illegal && m_ill != 8'd255) m_ill++;
            end
            if (fl) m_q.delete();
            else begin
                if (fout) void'(m_q.pop_front());
                if (fin) m_q.push_back(ref_decode(w));
            end
            if (m_q.size() > 0) m_rst = 1'b0;
        end
    endtask

    initial begin
        bit          acc;
        int          sent;
        logic [31:0] bw [4];
        logic [31:0] pw;
        bit          pv;
        logic [15:0] cnt_before;

        foreach (opmap[i]) opmap[i] = INVALID;
        opmap[6'h00] = SLL;  opmap[6'h01] = SLLI; opmap[6'h02] = SLR;  opmap[6'h03] = SLRI;
        opmap[6'h04] = ADD;  opmap[6'h05] = ADDI; opmap[6'h06] = SUB;  opmap[6'h07] = LAND;
        opmap[6'h08] = LOR;  opmap[6'h09] = LXOR;

        vt[0] = '{32'h0422_1805, SLLI, 5'd1, 5'd2, 5'd3, 6'd5, 1'b0};
        vt[1] = '{mk(6'h00, 5'd31, 5'd0, 5'd17, 5'h1F, 6'h3F), SLL, 5'd31, 5'd0, 5'd17, 6'h3F, 1'b0};
        vt[2] = '{mk(6'h02, 5'd7, 5'd8, 5'd9, 5'h00, 6'h00), SLR, 5'd7, 5'd8, 5'd9, 6'h00, 1'b0};
        vt[3] = '{mk(6'h03, 5'd10, 5'd11, 5'd12, 5'h15, 6'h2A), SLRI, 5'd10, 5'd11, 5'd12, 6'h2A, 1'b0};
        vt[4] = '{mk(6'h04, 5'd13, 5'd14, 5'd15, 5'h01, 6'h01), ADD, 5'd13, 5'd14, 5'd15, 6'h01, 1'b0};
        vt[5] = '{mk(6'h09, 5'd16, 5'd18, 5'd19, 5'h0F, 6'h20), LXOR, 5'd16, 5'd18, 5'd19, 6'h20, 1'b0};
        vt[6] = '{mk(6'h3F, 5'd4, 5'd5, 5'd6, 5'h0A, 6'h11), INVALID, 5'd4, 5'd5, 5'd6, 6'h11, 1'b1};
        vt[7] = '{mk(6'h2A, 5'd30, 5'd29, 5'd28, 5'h1F, 6'h3E), INVALID, 5'd30, 5'd29, 5'd28, 6'h3E, 1'b1};

        rst_i = 1'b1; instr_valid_i = 1'b0; instr_i = '0; dec_ready_i = 1'b0; flush_i = 1'b0;
        @(posedge clk);
        cycle(0, 0, 0, 0, 1, acc);
        cycle(0, 0, 0, 0, 1, acc);
        #1;
        chk("rst_ready_low", 32'(instr_ready_o), 32'd0);
        chk("rst_func", 32'(func_o), 32'(INVALID));
        cycle(0, 0, 0, 0, 0, acc);
        #1;
        chk("post_rst_ready", 32'(instr_ready_o), 32'd1);

        // Directed vectors, streamed at full rate
        for (int i = 0; i < 8; i++) begin
            cycle(1, vt[i].ins, 1, 0, 0, acc);
            #1;
            chk("tbl_valid", 32'(dec_valid_o), 32'd1);
            chk("tbl_func", 32'(func_o), 32'(vt[i].f));
            chk("tbl_rd", 32'(rd_addr_o), 32'(vt[i].rd));
            chk("tbl_rs1", 32'(rs1_addr_o), 32'(vt[i].rs1));
            chk("tbl_rs2", 32'(rs2_addr_o), 32'(vt[i].rs2));
            chk("tbl_imm", 32'(imm_o), 32'(vt[i].imm));
            chk("tbl_illegal", 32'(illegal_o), 32'(vt[i].ill));
            if (i == 1) chk("first_count", 32'(dec_count_o), 32'd1);
        end
        cycle(0, 0, 1, 0, 0, acc);
        #1;
        chk("tbl_dec_count", 32'(dec_count_o), 32'd8);
        chk("tbl_ill_count", 32'(illegal_count_o), 32'd2);

        // Backpressure: four words offered with execute stalled
        for (int i = 0; i < 4; i++) bw[i] = mk(6'h05, 5'(i + 1), 5'(i + 2), 5'(i + 3), 5'd0, 6'(i + 9));
        sent = 0;
        for (int c = 0; c < 3; c++) begin
            cycle(1, bw[sent], 0, 0, 0, acc);
            if (acc) sent++;
        end
        #1;
        chk("bp_accepted", 32'(sent), 32'd2);
        chk("bp_ready_low", 32'(instr_ready_o), 32'd0);
        chk("bp_hold_rd", 32'(rd_addr_o), 32'd1);
        for (int c = 0; c < 2; c++) begin
            cycle(1, bw[sent], 0, 0, 0, acc);
            if (acc) sent++;
        end
        for (int c = 0; c < 8 && sent < 4; c++) begin
            cycle(1, bw[sent], 1, 0, 0, acc);
            if (acc) sent++;
        end
        chk("bp_all_sent", 32'(sent), 32'd4);
        for (int c = 0; c < 4; c++) cycle(0, 0, 1, 0, 0, acc);
        #1;
        chk("bp_ready_back", 32'(instr_ready_o), 32'd1);
        chk("bp_drained", 32'(dec_valid_o), 32'd0);

        // Illegal saturation
        for (int i = 0; i < 300; i++) cycle(1, {6'h3F, 26'($urandom)}, 1, 0, 0, acc);
        cycle(0, 0, 1, 0, 0, acc);
        #1;
        chk("ill_saturate", 32'(illegal_count_o), 32'd255);

        // Flush with buffer full, word presented alongside
        cycle(1, mk(6'h06, 5'd1, 5'd1, 5'd1, 5'd0, 6'd1), 0, 0, 0, acc);
        cycle(1, mk(6'h07, 5'd2, 5'd2, 5'd2, 5'd0, 6'd2), 0, 0, 0, acc);
        cycle(1, mk(6'h08, 5'd3, 5'd3, 5'd3, 5'd0, 6'd3), 0, 1, 0, acc);
        #1;
        chk("flush_valid", 32'(dec_valid_o), 32'd0);
        chk("flush_ready", 32'(instr_ready_o), 32'd1);
        // Flush with one entry: the input handshake in the flush cycle is dropped
        cycle(1, mk(6'h04, 5'd5, 5'd5, 5'd5, 5'd0, 6'd5), 0, 0, 0, acc);
        cycle(1, mk(6'h01, 5'd6, 5'd6, 5'd6, 5'd0, 6'd6), 0, 1, 0, acc);
        cycle(0, 0, 1, 0, 0, acc);
        #1;
        chk("flush_drop", 32'(dec_valid_o), 32'd0);
        // Output handshake in a flush cycle still counts
        cycle(1, mk(6'h00, 5'd7, 5'd7, 5'd7, 5'd0, 6'd7), 1, 0, 0, acc);
        cnt_before = m_dec;
        cycle(0, 0, 1, 1, 0, acc);
        #1;
        chk("flush_hs_count", 32'(dec_count_o), 32'(cnt_before + 16'd1));

        // Randomized traffic with a held-until-accepted sender
        pv = 1'b0; pw = '0;
        for (int i = 0; i < 2000; i++) begin
            bit fl, rs, dr;
            logic [5:0] op;
            if (!pv && $urandom_range(0, 3) != 0) begin
                op = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 9)) : 6'($urandom_range(10, 63));
                pw = {op, 26'($urandom)};
                pv = 1'b1;
            end
            fl = ($urandom_range(0, 19) == 0);
            rs = ($urandom_range(0, 99) == 0);
            dr = ($urandom_range(0, 2) != 0);
            cycle(pv, pw, dr, fl, rs, acc);
            if (acc || fl || rs) pv = 1'b0;
        end

        // Reset mid-stream with both entries full
        cycle(0, 0, 1, 0, 0, acc);
        cycle(0, 0, 1, 0, 0, acc);
        cycle(1, mk(6'h02, 5'd9, 5'd9, 5'd9, 5'd0, 6'd9), 0, 0, 0, acc);
        cycle(1, mk(6'h03, 5'd8, 5'd8, 5'd8, 5'd0, 6'd8), 0, 0, 0, acc);
        cycle(0, 0, 0, 0, 1, acc);
        #1;
        chk("mid_rst_valid", 32'(dec_valid_o), 32'd0);
        chk("mid_rst_func", 32'(func_o), 32'(INVALID));
        chk("mid_rst_rd", 32'(rd_addr_o), 32'd0);
        chk("mid_rst_count", 32'(dec_count_o), 32'd0);
        chk("mid_rst_ready", 32'(instr_ready_o), 32'd0);
        cycle(0, 0, 1, 0, 0, acc);

        // Counter wrap
        for (int i = 0; i < 65535; i++) cycle(1, 32'h1000_0000 | 32'(i), 1, 0, 0, acc);
        cycle(0, 0, 1, 0, 0, acc);
        #1;
        chk("wrap_preload", 32'(dec_count_o), 32'd65535);
        cycle(1, 32'h0422_1805, 1, 0, 0, acc);
        cycle(0, 0, 1, 0, 0, acc);
        #1;
        chk("wrap_zero", 32'(dec_count_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
